// File: rtl/word_byte_serializer_pkg.sv
// Shared definitions for the word-to-byte serializer: FSM state encoding,
// default geometry and the lane-index width helper.
package word_byte_serializer_pkg;

  localparam int NBYTES_DEF = 4;
  localparam int BYTE_W_DEF = 8;

  typedef enum logic {
    ST_IDLE = 1'b0,
    ST_SEND = 1'b1
  } state_e;

  // A single-lane word still needs a 1-bit index so that port widths stay legal.
  function automatic int idx_width(input int nbytes);
    return (nbytes > 1) ? $clog2(nbytes) : 1;
  endfunction

endpackage

// File: rtl/word_byte_serializer_byte_lane_sel.sv
// Combinational NBYTES:1 byte-lane multiplexer; lane 0 is the most significant byte.
// With BYTE_ORDER_SEL_EN defined, lsb_first mirrors the lane index before the mux.
module byte_lane_sel
  import word_byte_serializer_pkg::*;
#(
  parameter int NBYTES = NBYTES_DEF,
  parameter int BYTE_W = BYTE_W_DEF,
  localparam int IDX_W = idx_width(NBYTES),
  localparam int W     = NBYTES * BYTE_W
) (
  input  logic [W-1:0]      word,
  input  logic [IDX_W-1:0]  idx,
`ifdef BYTE_ORDER_SEL_EN
  input  logic              lsb_first,
`endif
  output logic [BYTE_W-1:0] lane_byte
);

  logic [BYTE_W-1:0] lanes [NBYTES];
  logic [IDX_W-1:0]  sel;

  genvar gi;
  generate
    for (gi = 0; gi < NBYTES; gi++) begin : g_lane
      assign lanes[gi] = word[W-1-gi*BYTE_W -: BYTE_W];
    end
  endgenerate

  always_comb begin
    sel = idx;
`ifdef BYTE_ORDER_SEL_EN
    if (lsb_first) begin
      sel = IDX_W'(NBYTES - 1) - idx;
    end
`endif
  end

  assign lane_byte = lanes[sel];

endmodule

// File: rtl/word_byte_serializer.sv
// Serializes an NBYTES*BYTE_W word into a valid/ready byte stream, MSB lane first,
// with back-to-back word reload on the last byte. Optional macro: BYTE_ORDER_SEL_EN.
module word_byte_serializer
  import word_byte_serializer_pkg::*;
#(
  parameter int NBYTES = NBYTES_DEF,
  parameter int BYTE_W = BYTE_W_DEF
) (
  input  logic                     clk,
  input  logic                     reset,
  input  logic [NBYTES*BYTE_W-1:0] in_word,
  input  logic                     in_valid,
`ifdef BYTE_ORDER_SEL_EN
  input  logic                     in_lsb_first,
`endif
  output logic                     in_ready,
  output logic [BYTE_W-1:0]        out_byte,
  output logic                     out_valid,
  input  logic                     out_ready,
  output logic                     out_last,
  output logic                     busy
);

  localparam int W     = NBYTES * BYTE_W;
  localparam int IDX_W = idx_width(NBYTES);
  localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(NBYTES - 1);

  state_e           state_q, state_d;
  logic [IDX_W-1:0] idx_q, idx_d;
  logic [W-1:0]     word_q, word_d;
  logic             in_hs, out_hs;
  logic [BYTE_W-1:0] lane_byte;
`ifdef BYTE_ORDER_SEL_EN
  logic             order_q, order_d;
`endif

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q <= ST_IDLE;
      idx_q   <= '0;
      word_q  <= '0;
`ifdef BYTE_ORDER_SEL_EN
      order_q <= 1'b0;
`endif
    end else begin
      state_q <= state_d;
      idx_q   <= idx_d;
      word_q  <= word_d;
`ifdef BYTE_ORDER_SEL_EN
      order_q <= order_d;
`endif
    end
  end

  byte_lane_sel #(
    .NBYTES (NBYTES),
    .BYTE_W (BYTE_W)
  ) u_lane_sel (
    .word      (word_q),
    .idx       (idx_q),
`ifdef BYTE_ORDER_SEL_EN
    .lsb_first (order_q),
`endif
    .lane_byte (lane_byte)
  );

  // in_ready may only rise in SEND on the final-lane handshake, so a reload never
  // disturbs a word that still has lanes left to emit.
  always_comb begin
    out_valid = (state_q == ST_SEND);
    busy      = (state_q == ST_SEND);
    out_last  = (state_q == ST_SEND) && (idx_q == LAST_IDX);
    in_ready  = (state_q == ST_IDLE) || (out_last && out_ready);
    in_hs     = in_valid && in_ready;
    out_hs    = out_valid && out_ready;
    out_byte  = out_valid ? lane_byte : '0;
  end

  always_comb begin
    state_d = state_q;
    idx_d   = idx_q;
    word_d  = word_q;
`ifdef BYTE_ORDER_SEL_EN
    order_d = order_q;
`endif
    case (state_q)
      ST_IDLE: begin
        if (in_hs) begin
          state_d = ST_SEND;
          idx_d   = '0;
          word_d  = in_word;
`ifdef BYTE_ORDER_SEL_EN
          order_d = in_lsb_first;
`endif
        end
      end
      ST_SEND: begin
        if (out_hs) begin
          if (idx_q != LAST_IDX) begin
            idx_d = idx_q + 1'b1;
          end else if (in_hs) begin
            idx_d  = '0;
            word_d = in_word;
`ifdef BYTE_ORDER_SEL_EN
            order_d = in_lsb_first;
`endif
          end else begin
            state_d = ST_IDLE;
            idx_d   = '0;
          end
        end
      end
      default: begin
        state_d = ST_IDLE;
        idx_d   = '0;
      end
    endcase
  end

endmodule

// File: tb/tb_word_byte_serializer.sv
// Self-checking bench: directed literal sequences plus randomized traffic checked
// every cycle against a byte-queue model of the serializer.
module tb_word_byte_serializer;

  localparam int NBYTES = 4;
  localparam int BYTE_W = 8;
  localparam int W      = NBYTES * BYTE_W;

  logic              clk = 1'b0;
  logic              reset;
  logic [W-1:0]      in_word;
  logic              in_valid;
  logic              in_ready;
  logic [BYTE_W-1:0] out_byte;
  logic              out_valid;
  logic              out_ready;
  logic              out_last;
  logic              busy;
`ifdef BYTE_ORDER_SEL_EN
  logic              in_lsb_first;
`endif

  int n_cmp = 0;
  int n_bad = 0;
  bit chk_en = 1'b0;

  // Model: bytes still to be emitted, head = byte currently on the output.
  logic [BYTE_W-1:0] mq[$];

  always #5 clk = ~clk;

  word_byte_serializer #(
    .NBYTES (NBYTES),
    .BYTE_W (BYTE_W)
  ) dut (
    .clk          (clk),
    .reset        (reset),
    .in_word      (in_word),
    .in_valid     (in_valid),
`ifdef BYTE_ORDER_SEL_EN
    .in_lsb_first (in_lsb_first),
`endif
    .in_ready     (in_ready),
    .out_byte     (out_byte),
    .out_valid    (out_valid),
    .out_ready    (out_ready),
    .out_last     (out_last),
    .busy         (busy)
  );

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  function automatic void push_word(input logic [W-1:0] w, input bit lsb);
    for (int k = 0; k < NBYTES; k++) begin
      int lane;
      lane = lsb ? (NBYTES - 1 - k) : k;
      mq.push_back(w[W-1-lane*BYTE_W -: BYTE_W]);
    end
  endfunction

  always @(posedge clk or posedge reset) begin
    bit ov, ir, lsb;
    if (reset) begin
      mq.delete();
    end else begin
`ifdef BYTE_ORDER_SEL_EN
      lsb = in_lsb_first;
`else
      lsb = 1'b0;
`endif
      ov = (mq.size() > 0);
      ir = !ov || (mq.size() == 1 && out_ready);
      if (ov && out_ready) void'(mq.pop_front());
      if (in_valid && ir) push_word(in_word, lsb);
    end
  end

  always @(negedge clk) begin
    bit ov;
    if (chk_en) begin
      ov = (mq.size() > 0);
      check("m_out_valid", {31'd0, out_valid}, {31'd0, ov});
      check("m_busy", {31'd0, busy}, {31'd0, ov});
      check("m_out_last", {31'd0, out_last}, {31'd0, mq.size() == 1});
      check("m_in_ready", {31'd0, in_ready}, {31'd0, (!ov || (mq.size() == 1 && out_ready))});
      if (ov) check("m_out_byte", {24'd0, out_byte}, {24'd0, mq[0]});
    end
  end

  // Drive one cycle of inputs and compare against hand-computed literals.
  task automatic step(input string name, input bit iv, input logic [W-1:0] w, input bit lsb,
                      input bit ordy, input bit ev, input logic [7:0] eb, input bit el,
                      input bit eir);
    in_valid  = iv;
    in_word   = w;
    out_ready = ordy;
`ifdef BYTE_ORDER_SEL_EN
    in_lsb_first = lsb;
`else
    if (lsb) $display("note: byte-order flag ignored in this build");
`endif
    @(negedge clk);
    check({name, ".valid"}, {31'd0, out_valid}, {31'd0, ev});
    check({name, ".in_ready"}, {31'd0, in_ready}, {31'd0, eir});
    check({name, ".last"}, {31'd0, out_last}, {31'd0, el});
    if (ev) check({name, ".byte"}, {24'd0, out_byte}, {24'd0, eb});
    @(posedge clk);
    #1;
  endtask

  initial begin
    #2_000_000;
    $display("FAIL timeout: simulation did not finish");
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad + 1);
    $fatal(1, "timeout");
  end

  initial begin
    reset     = 1'b1;
    in_valid  = 1'b0;
    in_word   = '0;
    out_ready = 1'b0;
`ifdef BYTE_ORDER_SEL_EN
    in_lsb_first = 1'b0;
`endif
    #1;
    check("rst.out_valid", {31'd0, out_valid}, 32'd0);
    check("rst.out_byte", {24'd0, out_byte}, 32'd0);
    check("rst.out_last", {31'd0, out_last}, 32'd0);
    check("rst.busy", {31'd0, busy}, 32'd0);
    check("rst.in_ready", {31'd0, in_ready}, 32'd1);
    repeat (2) @(posedge clk);
    #1;
    reset  = 1'b0;
    chk_en = 1'b1;

    // Single word
    step("sw.acc", 1, 32'h11223344, 0, 1, 0, 8'h00, 0, 1);
    step("sw.b0",  0, 32'h0,        0, 1, 1, 8'h11, 0, 0);
    step("sw.b1",  0, 32'h0,        0, 1, 1, 8'h22, 0, 0);
    step("sw.b2",  0, 32'h0,        0, 1, 1, 8'h33, 0, 0);
    step("sw.b3",  0, 32'h0,        0, 1, 1, 8'h44, 1, 1);
    step("sw.idle", 0, 32'h0,       0, 1, 0, 8'h00, 0, 1);

    // Backpressure on byte 22
    step("bp.acc", 1, 32'h11223344, 0, 1, 0, 8'h00, 0, 1);
    step("bp.b0",  0, 32'h0,        0, 1, 1, 8'h11, 0, 0);
    for (int i = 0; i < 3; i++) step("bp.hold", 0, 32'h0, 0, 0, 1, 8'h22, 0, 0);
    step("bp.b1",  0, 32'h0,        0, 1, 1, 8'h22, 0, 0);
    step("bp.b2",  0, 32'h0,        0, 1, 1, 8'h33, 0, 0);
    step("bp.b3",  0, 32'h0,        0, 1, 1, 8'h44, 1, 1);
    step("bp.idle", 0, 32'h0,       0, 1, 0, 8'h00, 0, 1);

    // Back-to-back words
    step("bb.acc", 1, 32'hAABBCCDD, 0, 1, 0, 8'h00, 0, 1);
    step("bb.b0",  1, 32'h01020304, 0, 1, 1, 8'hAA, 0, 0);
    step("bb.b1",  1, 32'h01020304, 0, 1, 1, 8'hBB, 0, 0);
    step("bb.b2",  1, 32'h01020304, 0, 1, 1, 8'hCC, 0, 0);
    step("bb.b3",  1, 32'h01020304, 0, 1, 1, 8'hDD, 1, 1);
    step("bb.b4",  0, 32'h0,        0, 1, 1, 8'h01, 0, 0);
    step("bb.b5",  0, 32'h0,        0, 1, 1, 8'h02, 0, 0);
    step("bb.b6",  0, 32'h0,        0, 1, 1, 8'h03, 0, 0);
    step("bb.b7",  0, 32'h0,        0, 1, 1, 8'h04, 1, 1);
    step("bb.idle", 0, 32'h0,       0, 1, 0, 8'h00, 0, 1);

    // Reset mid-word, right after byte 22 is taken
    step("rm.acc", 1, 32'h11223344, 0, 1, 0, 8'h00, 0, 1);
    step("rm.b0",  0, 32'h0,        0, 1, 1, 8'h11, 0, 0);
    step("rm.b1",  0, 32'h0,        0, 1, 1, 8'h22, 0, 0);
    #2;
    reset = 1'b1;
    #1;
    check("rm.async_valid", {31'd0, out_valid}, 32'd0);
    check("rm.async_busy", {31'd0, busy}, 32'd0);
    check("rm.async_last", {31'd0, out_last}, 32'd0);
    @(posedge clk);
    #1;
    reset = 1'b0;
    for (int i = 0; i < 4; i++) step("rm.after", 0, 32'h0, 0, 1, 0, 8'h00, 0, 1);

    // Idle
    for (int i = 0; i < 8; i++) step("idle", 0, $urandom, 0, 1'($urandom_range(0, 1)), 0, 8'h00, 0, 1);

`ifdef BYTE_ORDER_SEL_EN
    step("lo.acc", 1, 32'h11223344, 1, 1, 0, 8'h00, 0, 1);
    step("lo.b0",  0, 32'h0,        0, 1, 1, 8'h44, 0, 0);
    step("lo.b1",  0, 32'h0,        0, 1, 1, 8'h33, 0, 0);
    step("lo.b2",  0, 32'h0,        0, 1, 1, 8'h22, 0, 0);
    step("lo.b3",  0, 32'h0,        0, 1, 1, 8'h11, 1, 1);
`endif

    // Randomized traffic with occasional resets
    for (int i = 0; i < 4000; i++) begin
      in_valid  = ($urandom_range(0, 9) < 7);
      in_word   = $urandom;
      out_ready = ($urandom_range(0, 9) < 7);
`ifdef BYTE_ORDER_SEL_EN
      in_lsb_first = 1'($urandom_range(0, 1));
`endif
      @(posedge clk);
      #1;
      if ($urandom_range(0, 499) == 0) begin
        #2;
        reset = 1'b1;
        @(posedge clk);
        #1;
        reset = 1'b0;
      end
    end

    in_valid = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    chk_en = 1'b0;
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
